// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_pkg;

  localparam int unsigned REG_DATA_WIDTH = 32;
  localparam int unsigned REG_NUM        = 32;
  localparam int unsigned REG_ADDR_WIDTH = $clog2(REG_NUM);

  typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [REG_DATA_WIDTH-1:0] reg_data_t;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_t;

endpackage

// File: rtl/multi_port_register_file_if.sv
// Read/write/issue bundle between issue/writeback stages and the register file.
interface multi_port_register_file_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = REG_DATA_WIDTH,
  parameter int unsigned NUM_REGS   = REG_NUM,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned NUM_WRITE  = 1
) ();
  localparam int unsigned AW = $clog2(NUM_REGS);

  logic                                  ready;
  logic [NUM_READ-1:0][AW-1:0]           raddr;
  logic [NUM_READ-1:0][DATA_WIDTH-1:0]   rdata;
  logic [NUM_READ-1:0]                   rbusy;
  logic [NUM_WRITE-1:0]                  wen;
  logic [NUM_WRITE-1:0][AW-1:0]          waddr;
  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0]  wdata;
  logic                                  issue_valid;
  logic [AW-1:0]                         issue_addr;

  modport master (
    input  ready, rdata, rbusy,
    output raddr, wen, waddr, wdata, issue_valid, issue_addr
  );

  modport slave (
    output ready, rdata, rbusy,
    input  raddr, wen, waddr, wdata, issue_valid, issue_addr
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write busy bits. Writes clear, issues set; set wins on
// a same-cycle collision because the newly issued producer is still outstanding.
module regfile_scoreboard #(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned NUM_WRITE = 1,
  parameter int unsigned AW        = $clog2(NUM_REGS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  input  logic [NUM_WRITE-1:0]         wen,
  input  logic [NUM_WRITE-1:0][AW-1:0] waddr,
  input  logic                         issue_valid,
  input  logic [AW-1:0]                issue_addr,
  output logic [NUM_REGS-1:0]          busy
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  // Next busy vector: clears from writeback first, then the issue set overrides.
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      for (int i = 0; i < NUM_WRITE; i++) begin
        if (wen[i] && (waddr[i] != '0)) busy_d[waddr[i]] = 1'b0;
      end
      if (issue_valid && (issue_addr != '0)) busy_d[issue_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Busy state register.
  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy = busy_q;

endmodule

// File: rtl/multi_port_register_file.sv
// Multi-port register file with scoreboard and a sequential reset sweep, so the
// storage array itself needs no reset and can map to distributed RAM.
// Optional macro: REGFILE_BYPASS_EN forwards same-cycle write data to reads.
module multi_port_register_file
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = REG_DATA_WIDTH,
  parameter int unsigned NUM_REGS   = REG_NUM,
  parameter int unsigned NUM_READ   = 2,
  parameter int unsigned NUM_WRITE  = 1
) (
  input logic                      clk,
  input logic                      rst,
  multi_port_register_file_if.slave bus
);
  localparam int unsigned AW = $clog2(NUM_REGS);

  rf_state_t           state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic                run;
  logic [NUM_REGS-1:0] busy;
  logic [DATA_WIDTH-1:0] mem [NUM_REGS];

  assign run       = (state_q == RF_RUN);
  assign bus.ready = run;

  // Sweep FSM: step through every entry once, then run.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == RF_INIT) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == AW'(NUM_REGS - 1)) state_d = RF_RUN;
    end
  end

  // FSM state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RF_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage: sweep clears while initialising; later ports override earlier ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) begin
        mem[cnt_q] <= '0;
      end else begin
        for (int i = 0; i < NUM_WRITE; i++) begin
          if (bus.wen[i] && (bus.waddr[i] != '0)) mem[bus.waddr[i]] <= bus.wdata[i];
        end
      end
    end
  end

  regfile_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .NUM_WRITE (NUM_WRITE),
    .AW        (AW)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .wen         (bus.wen),
    .waddr       (bus.waddr),
    .issue_valid (bus.issue_valid),
    .issue_addr  (bus.issue_addr),
    .busy        (busy)
  );

  // Read muxes; register 0 and the whole INIT phase read as zero / not busy.
  always_comb begin
    for (int k = 0; k < NUM_READ; k++) begin
      bus.rdata[k] = '0;
      bus.rbusy[k] = 1'b0;
      if (run && (bus.raddr[k] != '0)) begin
        bus.rdata[k] = mem[bus.raddr[k]];
        bus.rbusy[k] = busy[bus.raddr[k]];
`ifdef REGFILE_BYPASS_EN
        for (int i = 0; i < NUM_WRITE; i++) begin
          if (bus.wen[i] && (bus.waddr[i] == bus.raddr[k])) begin
            bus.rdata[k] = bus.wdata[i];
            // A same-cycle re-issue keeps the stored bit; its new set lands next cycle.
            if (!(bus.issue_valid && (bus.issue_addr == bus.raddr[k]))) bus.rbusy[k] = 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_multi_port_register_file.sv
// Directed self-checking bench for multi_port_register_file (2 read, 2 write ports).
module tb_multi_port_register_file;

  localparam int unsigned DW  = 32;
  localparam int unsigned NR  = 32;
  localparam int unsigned NRD = 2;
  localparam int unsigned NWR = 2;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  multi_port_register_file_if #(
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .NUM_READ   (NRD),
    .NUM_WRITE  (NWR)
  ) bus ();

  multi_port_register_file #(
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .NUM_READ   (NRD),
    .NUM_WRITE  (NWR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.wen         = '0;
    bus.waddr       = '0;
    bus.wdata       = '0;
    bus.issue_valid = 1'b0;
    bus.issue_addr  = '0;
  endtask

  // Counts cycles until ready, bounded; the count must equal the register count.
  task automatic wait_ready(input string tag);
    int n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    check(tag, 64'(n), 64'(NR));
  endtask

  initial begin
    rst = 1'b1;
    idle_bus();
    bus.raddr = '0;
    repeat (3) step();
    bus.raddr[0] = 5'd7;
    #1;
    check("reset_ready", 64'(bus.ready), 64'd0);
    check("reset_rbusy", 64'(bus.rbusy), 64'd0);
    check("reset_rdata", 64'(bus.rdata[0]), 64'd0);

    // Reset sweep length and cleared contents.
    rst = 1'b0;
    wait_ready("sweep_len");
    for (int r = 0; r < int'(NR); r++) begin
      bus.raddr[0] = 5'(r);
      #1;
      check($sformatf("sweep_zero_%0d", r), 64'(bus.rdata[0]), 64'd0);
    end

    // Write then read, including the same-cycle view.
    bus.wen      = 2'b01;
    bus.waddr[0] = 5'd5;
    bus.wdata[0] = 32'hDEADBEEF;
    bus.raddr[0] = 5'd5;
    bus.raddr[1] = 5'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("wr_same_cycle", 64'(bus.rdata[0]), 64'hDEADBEEF);
`else
    check("wr_same_cycle", 64'(bus.rdata[0]), 64'd0);
`endif
    step();
    idle_bus();
    #1;
    check("wr_next_p0", 64'(bus.rdata[0]), 64'hDEADBEEF);
    check("wr_next_p1", 64'(bus.rdata[1]), 64'hDEADBEEF);

    // Register 0 ignores writes and issues.
    bus.wen         = 2'b01;
    bus.waddr[0]    = 5'd0;
    bus.wdata[0]    = 32'h12345678;
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 5'd0;
    bus.raddr[0]    = 5'd0;
    step();
    idle_bus();
    #1;
    check("r0_data", 64'(bus.rdata[0]), 64'd0);
    check("r0_busy", 64'(bus.rbusy[0]), 64'd0);
    step();
    check("r0_data_later", 64'(bus.rdata[0]), 64'd0);
    check("r0_busy_later", 64'(bus.rbusy[0]), 64'd0);

    // Write conflict: port 1 wins.
    bus.wen      = 2'b11;
    bus.waddr[0] = 5'd7;
    bus.wdata[0] = 32'h1111;
    bus.waddr[1] = 5'd7;
    bus.wdata[1] = 32'h2222;
    step();
    // Two distinct targets in one cycle both land.
    bus.waddr[0] = 5'd9;
    bus.wdata[0] = 32'h3333;
    bus.waddr[1] = 5'd10;
    bus.wdata[1] = 32'h4444;
    step();
    idle_bus();
    bus.raddr[0] = 5'd7;
    bus.raddr[1] = 5'd9;
    #1;
    check("conflict_hi_wins", 64'(bus.rdata[0]), 64'h2222);
    check("dual_write_p0", 64'(bus.rdata[1]), 64'h3333);
    bus.raddr[1] = 5'd10;
    #1;
    check("dual_write_p1", 64'(bus.rdata[1]), 64'h4444);

    // Scoreboard set, clear, and set-wins collision.
    bus.raddr[1]    = 5'd3;
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 5'd3;
    #1;
    check("sb_before_issue", 64'(bus.rbusy[1]), 64'd0);
    step();
    idle_bus();
    #1;
    check("sb_issue_set", 64'(bus.rbusy[1]), 64'd1);
    check("sb_other_clear", 64'(bus.rbusy[0]), 64'd0);
    bus.wen      = 2'b10;
    bus.waddr[1] = 5'd3;
    bus.wdata[1] = 32'hAA;
    step();
    idle_bus();
    #1;
    check("sb_write_clear", 64'(bus.rbusy[1]), 64'd0);
    check("sb_write_data", 64'(bus.rdata[1]), 64'hAA);
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 5'd3;
    bus.wen         = 2'b01;
    bus.waddr[0]    = 5'd3;
    bus.wdata[0]    = 32'hBB;
    step();
    idle_bus();
    #1;
    check("sb_set_wins", 64'(bus.rbusy[1]), 64'd1);
    check("sb_set_wins_data", 64'(bus.rdata[1]), 64'hBB);

    // Mid-sweep reset: sweep restarts and INIT-time traffic leaves no trace.
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (10) step();
    check("mid_sweep_not_ready", 64'(bus.ready), 64'd0);
    rst = 1'b1;
    bus.raddr[0] = 5'd7;
    step();
    #1;
    check("init_rdata_zero", 64'(bus.rdata[0]), 64'd0);
    rst = 1'b0;
    bus.wen         = 2'b01;
    bus.waddr[0]    = 5'd9;
    bus.wdata[0]    = 32'hCAFE;
    bus.issue_valid = 1'b1;
    bus.issue_addr  = 5'd6;
    wait_ready("resweep_len");
    idle_bus();
    bus.raddr[0] = 5'd9;
    bus.raddr[1] = 5'd6;
    #1;
    check("init_write_dropped", 64'(bus.rdata[0]), 64'd0);
    check("init_issue_dropped", 64'(bus.rbusy[1]), 64'd0);
    bus.raddr[0] = 5'd7;
    bus.raddr[1] = 5'd3;
    #1;
    check("resweep_cleared", 64'(bus.rdata[0]), 64'd0);
    check("resweep_busy_clear", 64'(bus.rbusy[1]), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
